// File: rtl/frame_checker.sv
// Receive-side pattern checker for the frame generator stream.
// Each beat must carry the same 16-bit running counter in every lane.
// Frames, mismatched beats and the first error location are counted and
// read back through a small AXI4-Lite register slave.
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | not armed; tready low; counters hold their last values
// S_RUN  | armed for `limit` frames; every valid beat is accepted
module frame_checker #(
   parameter int AW = 8,
   parameter int DW = 512
) (
   input  logic          clk,
   input  logic          resetn,
   input  logic [31:0]   frame_size,
   input  logic [DW-1:0] axis_in_tdata,
   input  logic          axis_in_tvalid,
   output logic          axis_in_tready,
   input  logic [AW-1:0] S_AXI_AWADDR,
   input  logic          S_AXI_AWVALID,
   output logic          S_AXI_AWREADY,
   input  logic [2:0]    S_AXI_AWPROT,
   input  logic [31:0]   S_AXI_WDATA,
   input  logic [3:0]    S_AXI_WSTRB,
   input  logic          S_AXI_WVALID,
   output logic          S_AXI_WREADY,
   output logic [1:0]    S_AXI_BRESP,
   output logic          S_AXI_BVALID,
   input  logic          S_AXI_BREADY,
   input  logic [AW-1:0] S_AXI_ARADDR,
   input  logic          S_AXI_ARVALID,
   output logic          S_AXI_ARREADY,
   input  logic [2:0]    S_AXI_ARPROT,
   output logic [31:0]   S_AXI_RDATA,
   output logic [1:0]    S_AXI_RRESP,
   output logic          S_AXI_RVALID,
   input  logic          S_AXI_RREADY
);

   localparam int LANES = DW / 16;
   localparam int BYTES = DW / 8;
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   typedef enum logic {S_IDLE, S_RUN} state_t;
   state_t state, state_n;

   logic [31:0] bpf;
   logic [15:0] expected;
   logic [31:0] beat, frame, limit;
   logic [31:0] frames_rcvd, error_count, first_err_frame, first_err_beat;
   logic        config_err;

   logic        wr_fire, rd_fire, arm_req, abort_req;
   logic        beat_fire, last_beat, beat_ok;
   logic [31:0] wr_idx, rd_idx;
   logic [1:0]  wr_resp_n, rd_resp_n;
   logic [31:0] rd_data_n;

   // Protection, strobes and byte-offset bits carry no meaning for word registers.
   logic unused_ok;
   assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_WSTRB,
                        S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

   assign bpf       = frame_size / 32'(BYTES);
   assign wr_fire   = S_AXI_AWVALID & S_AXI_WVALID & ~S_AXI_BVALID;
   assign rd_fire   = S_AXI_ARVALID & ~S_AXI_RVALID;
   assign wr_idx    = 32'(S_AXI_AWADDR[AW-1:2]);
   assign rd_idx    = 32'(S_AXI_ARADDR[AW-1:2]);
   assign arm_req   = wr_fire && (wr_idx == 32'd0) && (S_AXI_WDATA != 32'd0);
   assign abort_req = wr_fire && (wr_idx == 32'd0) && (S_AXI_WDATA == 32'd0);

   assign axis_in_tready = (state == S_RUN);
   assign beat_fire      = axis_in_tvalid & axis_in_tready;
   assign last_beat      = (beat == bpf);

   assign S_AXI_AWREADY = wr_fire;
   assign S_AXI_WREADY  = wr_fire;
   assign S_AXI_ARREADY = rd_fire;

   // A beat is good only when every 16-bit lane carries the expected count.
   always_comb begin
      beat_ok = 1'b1;
      for (int i = 0; i < LANES; i++) begin
         if (axis_in_tdata[i*16 +: 16] != expected) beat_ok = 1'b0;
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (!resetn) state <= S_IDLE;
      else         state <= state_n;
   end

   // Next state: arm from idle, leave run on abort or after the final frame.
   always_comb begin
      state_n = state;
      case (state)
         S_IDLE: if (arm_req && (bpf != 32'd0)) state_n = S_RUN;
         S_RUN:  if (abort_req || (beat_fire && last_beat && (frame == limit)))
                    state_n = S_IDLE;
         default: state_n = S_IDLE;
      endcase
   end

   // Arm-time clearing and per-beat counting; a beat coinciding with abort is still counted.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         expected        <= 16'd0;
         beat            <= 32'd0;
         frame           <= 32'd0;
         limit           <= 32'd0;
         frames_rcvd     <= 32'd0;
         error_count     <= 32'd0;
         first_err_frame <= 32'd0;
         first_err_beat  <= 32'd0;
         config_err      <= 1'b0;
      end else begin
         if ((state == S_IDLE) && arm_req) begin
            if (bpf == 32'd0) begin
               config_err <= 1'b1;
            end else begin
               config_err      <= 1'b0;
               frames_rcvd     <= 32'd0;
               error_count     <= 32'd0;
               first_err_frame <= 32'd0;
               first_err_beat  <= 32'd0;
               expected        <= 16'd0;
               beat            <= 32'd1;
               frame           <= 32'd1;
               limit           <= S_AXI_WDATA;
            end
         end
         if (beat_fire) begin
            if (!beat_ok) begin
               if (error_count != 32'hFFFF_FFFF) error_count <= error_count + 32'd1;
               if (error_count == 32'd0) begin
                  first_err_frame <= frame;
                  first_err_beat  <= beat;
               end
            end
            expected <= expected + 16'd1;
            if (last_beat) begin
               beat        <= 32'd1;
               frames_rcvd <= frames_rcvd + 32'd1;
               if (frame != limit) frame <= frame + 32'd1;
            end else begin
               beat <= beat + 32'd1;
            end
         end
      end
   end

   // Write response decode: nonzero CONTROL while running and read-only indices are slave errors.
   always_comb begin
      wr_resp_n = RESP_OKAY;
      if (wr_idx == 32'd0) begin
         if ((S_AXI_WDATA != 32'd0) && (state == S_RUN)) wr_resp_n = RESP_SLVERR;
      end else if (wr_idx <= 32'd4) begin
         wr_resp_n = RESP_SLVERR;
      end else begin
         wr_resp_n = RESP_DECERR;
      end
   end

   // Read mux over the live register state.
   always_comb begin
      rd_data_n = 32'd0;
      rd_resp_n = RESP_OKAY;
      case (rd_idx)
         32'd0:   rd_data_n = {30'd0, config_err, (state == S_RUN)};
         32'd1:   rd_data_n = frames_rcvd;
         32'd2:   rd_data_n = error_count;
         32'd3:   rd_data_n = first_err_frame;
         32'd4:   rd_data_n = first_err_beat;
         default: rd_resp_n = RESP_DECERR;
      endcase
   end

   // AXI response channels: one response outstanding per direction.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         S_AXI_BVALID <= 1'b0;
         S_AXI_BRESP  <= RESP_OKAY;
         S_AXI_RVALID <= 1'b0;
         S_AXI_RDATA  <= 32'd0;
         S_AXI_RRESP  <= RESP_OKAY;
      end else begin
         if (wr_fire) begin
            S_AXI_BVALID <= 1'b1;
            S_AXI_BRESP  <= wr_resp_n;
         end else if (S_AXI_BREADY) begin
            S_AXI_BVALID <= 1'b0;
         end
         if (rd_fire) begin
            S_AXI_RVALID <= 1'b1;
            S_AXI_RDATA  <= rd_data_n;
            S_AXI_RRESP  <= rd_resp_n;
         end else if (S_AXI_RREADY) begin
            S_AXI_RVALID <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_frame_checker.sv
// Randomized bench for frame_checker. The reference keeps one global beat
// index since arming; the expected lane value, frame and beat-in-frame of any
// beat follow from that index by plain arithmetic.
module tb_frame_checker;

   localparam int AW = 8;
   localparam int DW = 512;

   logic          clk = 1'b0;
   logic          resetn;
   logic [31:0]   frame_size;
   logic [DW-1:0] axis_in_tdata;
   logic          axis_in_tvalid;
   logic          axis_in_tready;
   logic [AW-1:0] S_AXI_AWADDR;
   logic          S_AXI_AWVALID, S_AXI_AWREADY;
   logic [2:0]    S_AXI_AWPROT;
   logic [31:0]   S_AXI_WDATA;
   logic [3:0]    S_AXI_WSTRB;
   logic          S_AXI_WVALID, S_AXI_WREADY;
   logic [1:0]    S_AXI_BRESP;
   logic          S_AXI_BVALID, S_AXI_BREADY;
   logic [AW-1:0] S_AXI_ARADDR;
   logic          S_AXI_ARVALID, S_AXI_ARREADY;
   logic [2:0]    S_AXI_ARPROT;
   logic [31:0]   S_AXI_RDATA;
   logic [1:0]    S_AXI_RRESP;
   logic          S_AXI_RVALID, S_AXI_RREADY;

   int total = 0;
   int bad   = 0;
   int model_g;
   logic [1:0]  resp;
   logic [31:0] rdat;

   always #5 clk = ~clk;

   frame_checker #(.AW(AW), .DW(DW)) dut (
      .clk(clk), .resetn(resetn), .frame_size(frame_size),
      .axis_in_tdata(axis_in_tdata), .axis_in_tvalid(axis_in_tvalid),
      .axis_in_tready(axis_in_tready),
      .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWVALID(S_AXI_AWVALID),
      .S_AXI_AWREADY(S_AXI_AWREADY), .S_AXI_AWPROT(S_AXI_AWPROT),
      .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
      .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
      .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID),
      .S_AXI_BREADY(S_AXI_BREADY),
      .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARVALID(S_AXI_ARVALID),
      .S_AXI_ARREADY(S_AXI_ARREADY), .S_AXI_ARPROT(S_AXI_ARPROT),
      .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
      .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Beat g carries g mod 65536 in every lane; a corrupted beat has one lane altered.
   function automatic logic [DW-1:0] pat(input int g, input bit corrupt);
      logic [DW-1:0] d;
      logic [15:0]   v;
      int            ln;
      v = g[15:0];
      for (int i = 0; i < DW/16; i++) d[i*16 +: 16] = v;
      if (corrupt) begin
         ln = int'($urandom_range(0, DW/16 - 1));
         d[ln*16 +: 16] = v ^ 16'h8001;
      end
      return d;
   endfunction

   task automatic axi_write(input logic [AW-1:0] addr, input logic [31:0] data,
                            output logic [1:0] r);
      int n;
      @(negedge clk);
      S_AXI_AWADDR = addr; S_AXI_WDATA = data;
      S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
      #1;
      n = 0;
      while (!(S_AXI_AWREADY && S_AXI_WREADY) && n < 50) begin
         @(negedge clk); #1; n++;
      end
      if (n >= 50) check("aw_handshake_timeout", 32'd0, 32'd1);
      @(negedge clk);
      S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
      check("bvalid", {31'd0, S_AXI_BVALID}, 32'd1);
      r = S_AXI_BRESP;
   endtask

   task automatic axi_read(input logic [AW-1:0] addr, output logic [31:0] d,
                           output logic [1:0] r);
      int n;
      @(negedge clk);
      S_AXI_ARADDR = addr; S_AXI_ARVALID = 1'b1;
      #1;
      n = 0;
      while (!S_AXI_ARREADY && n < 50) begin
         @(negedge clk); #1; n++;
      end
      if (n >= 50) check("ar_handshake_timeout", 32'd0, 32'd1);
      @(negedge clk);
      S_AXI_ARVALID = 1'b0;
      d = S_AXI_RDATA;
      r = S_AXI_RRESP;
   endtask

   task automatic rd_check(input string tag, input int idx, input logic [31:0] exp);
      logic [31:0] d;
      logic [1:0]  r;
      axi_read(AW'(idx * 4), d, r);
      check(tag, d, exp);
   endtask

   task automatic arm(input logic [31:0] n);
      logic [1:0] r;
      axi_write(8'h00, n, r);
      check("arm_bresp", {30'd0, r}, 32'd0);
      model_g = 0;
   endtask

   // Presents n beats whenever tready allows (with random gaps); bad1/bad2 are global indices to corrupt.
   task automatic drive_beats(input int n, input int gap_pct, input int bad1, input int bad2);
      int got, cyc;
      got = 0; cyc = 0;
      while (got < n && cyc < 4*n + 100) begin
         @(negedge clk); cyc++;
         if (axis_in_tready && (int'($urandom_range(0, 99)) >= gap_pct)) begin
            axis_in_tdata  = pat(model_g, (model_g == bad1) || (model_g == bad2));
            axis_in_tvalid = 1'b1;
            model_g++;
            got++;
         end else begin
            axis_in_tvalid = 1'b0;
         end
      end
      check("beats_accepted", got, n);
      @(negedge clk);
      axis_in_tvalid = 1'b0;
   endtask

   initial begin
      #1_500_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      resetn = 1'b0; frame_size = 32'd1024;
      axis_in_tdata = '0; axis_in_tvalid = 1'b0;
      S_AXI_AWADDR = '0; S_AXI_AWVALID = 1'b0; S_AXI_AWPROT = 3'd0;
      S_AXI_WDATA = '0; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b0;
      S_AXI_BREADY = 1'b1; S_AXI_ARADDR = '0; S_AXI_ARVALID = 1'b0;
      S_AXI_ARPROT = 3'd0; S_AXI_RREADY = 1'b1;
      model_g = 0;
      repeat (3) @(negedge clk);
      resetn = 1'b1;

      // reset state
      check("rst_tready", {31'd0, axis_in_tready}, 32'd0);
      check("rst_bvalid", {31'd0, S_AXI_BVALID}, 32'd0);
      check("rst_rvalid", {31'd0, S_AXI_RVALID}, 32'd0);
      for (int i = 0; i < 5; i++) rd_check("rst_reg", i, 32'd0);

      // three clean frames of 16 beats
      arm(32'd3);
      check("arm_tready", {31'd0, axis_in_tready}, 32'd1);
      drive_beats(48, 0, -1, -1);
      check("end_tready", {31'd0, axis_in_tready}, 32'd0);
      rd_check("clean_control", 0, 32'd0);
      rd_check("clean_frames", 1, 32'd3);
      rd_check("clean_errors", 2, 32'd0);
      rd_check("clean_fef", 3, 32'd0);
      rd_check("clean_feb", 4, 32'd0);

      // frame 2 beat 5 corrupted, random gaps
      arm(32'd3);
      drive_beats(48, 20, 16 + 4, -1);
      check("err1_tready", {31'd0, axis_in_tready}, 32'd0);
      rd_check("err1_frames", 1, 32'd3);
      rd_check("err1_errors", 2, 32'd1);
      rd_check("err1_fef", 3, 32'd2);
      rd_check("err1_feb", 4, 32'd5);

      // two errors: the first location must stick
      arm(32'd2);
      drive_beats(32, 10, 3, 30);
      rd_check("err2_frames", 1, 32'd2);
      rd_check("err2_errors", 2, 32'd2);
      rd_check("err2_fef", 3, 32'd1);
      rd_check("err2_feb", 4, 32'd4);

      // abort with a coincident beat; nonzero write mid-run rejected
      arm(32'd10);
      drive_beats(3, 0, -1, -1);
      axi_write(8'h00, 32'd5, resp);
      check("rearm_run_bresp", {30'd0, resp}, 32'h2);
      check("rearm_run_tready", {31'd0, axis_in_tready}, 32'd1);
      drive_beats(4, 0, -1, -1);
      @(negedge clk);
      axis_in_tdata = pat(model_g, 1'b1); axis_in_tvalid = 1'b1; model_g++;
      S_AXI_AWADDR = 8'h00; S_AXI_WDATA = 32'd0;
      S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
      #1;
      check("abort_same_cycle", {31'd0, S_AXI_AWREADY & axis_in_tready}, 32'd1);
      @(negedge clk);
      S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; axis_in_tvalid = 1'b0;
      check("abort_bvalid", {31'd0, S_AXI_BVALID}, 32'd1);
      check("abort_bresp", {30'd0, S_AXI_BRESP}, 32'd0);
      check("abort_tready", {31'd0, axis_in_tready}, 32'd0);
      rd_check("abort_control", 0, 32'd0);
      rd_check("abort_frames", 1, 32'd0);
      rd_check("abort_errors", 2, 32'd1);
      rd_check("abort_fef", 3, 32'd1);
      rd_check("abort_feb", 4, 32'd8);

      // one-beat frames across the 16-bit counter wrap
      frame_size = 32'd64;
      arm(32'd65600);
      drive_beats(65600, 3, -1, -1);
      check("wrap_tready", {31'd0, axis_in_tready}, 32'd0);
      rd_check("wrap_frames", 1, 32'd65600);
      rd_check("wrap_errors", 2, 32'd0);
      rd_check("wrap_control", 0, 32'd0);

      // frame smaller than one beat, decode errors
      frame_size = 32'd32;
      axi_write(8'h00, 32'd1, resp);
      check("cfgerr_bresp", {30'd0, resp}, 32'd0);
      rd_check("cfgerr_control", 0, 32'h2);
      axis_in_tdata = '1; axis_in_tvalid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("cfgerr_tready", {31'd0, axis_in_tready}, 32'd0);
      end
      axis_in_tvalid = 1'b0;
      rd_check("cfgerr_frames_kept", 1, 32'd65600);
      rd_check("cfgerr_errors_kept", 2, 32'd0);
      axi_read(8'd28, rdat, resp);
      check("rd_idx7_rresp", {30'd0, resp}, 32'h3);
      axi_write(8'd8, 32'd1, resp);
      check("wr_idx2_bresp", {30'd0, resp}, 32'h2);
      axi_write(8'd36, 32'd1, resp);
      check("wr_idx9_bresp", {30'd0, resp}, 32'h3);
      frame_size = 32'd1024;
      arm(32'd1);
      rd_check("cfgerr_cleared", 0, 32'h1);
      drive_beats(16, 0, -1, -1);

      // reset mid-frame, then a clean re-run
      arm(32'd2);
      drive_beats(5, 0, 2, -1);
      @(negedge clk);
      resetn = 1'b0;
      @(negedge clk);
      resetn = 1'b1;
      check("midrst_tready", {31'd0, axis_in_tready}, 32'd0);
      for (int i = 0; i < 5; i++) rd_check("midrst_reg", i, 32'd0);
      arm(32'd1);
      drive_beats(16, 25, -1, -1);
      rd_check("rerun_frames", 1, 32'd1);
      rd_check("rerun_errors", 2, 32'd0);
      rd_check("rerun_control", 0, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/frame_checker.md
# frame_checker

Receive-side counterpart of the frame generator. The block consumes an AXI4-Stream of fixed-size frames and checks every beat against the generator's pattern: a 16-bit counter replicated across all lanes. It counts frames and mismatches and records the location of the first error. It is controlled and read through an AXI4-Lite slave built on the team's `axi4_lite_slave` core (ASHI interface).

## Interface
Parameters:
- AW, 8, AXI4-Lite address width; address mask = (1<<AW)-1
- DW, 512, stream data width in bits; must be a multiple of 16

Ports:
- clk  in  1  clock
- resetn  in  1  reset, synchronous, active-low
- frame_size  in  32  frame length in bytes, shared with the generator
- axis_in_tdata  in  DW  stream data
- axis_in_tvalid  in  1  stream valid
- axis_in_tready  out  1  stream ready
- S_AXI_AW*/W*/B*/AR*/R*  AXI4-Lite slave:
  - AWADDR[AW], AWVALID, AWREADY, AWPROT[3]
  - WDATA[32], WSTRB[4], WVALID, WREADY
  - BRESP[2], BVALID, BREADY
  - ARADDR[AW], ARVALID, ARREADY, ARPROT[3]
  - RDATA[32], RRESP[2], RVALID, RREADY

## Operation
- Register map (index = address/4):
  - 0 CONTROL
    - Write of a nonzero value N: arm the checker for N frames.
    - Write of 0: abort.
    - Read: bit0 = busy, bit1 = config_err.
  - 1 FRAMES_RCVD: read-only; number of frames completed.
  - 2 ERROR_COUNT: read-only; number of mismatched beats, saturates at 0xFFFFFFFF.
  - 3 FIRST_ERR_FRAME: read-only; 1-based frame number of the first mismatch; 0 if none.
  - 4 FIRST_ERR_BEAT: read-only; 1-based beat-within-frame of the first mismatch; 0 if none.
- Any other read or write index returns DECERR. Writes to indices 1-4 return SLVERR.
- beats_per_frame = frame_size / (DW/8), 32-bit integer divide.
- FSM states:
  - IDLE
    - On a nonzero CONTROL write with beats_per_frame != 0:
      - clear FRAMES_RCVD, ERROR_COUNT, FIRST_ERR_*, config_err;
      - expected = 0, beat = 1, frame = 1, limit = N;
      - go to RUN.
    - If beats_per_frame == 0: set config_err, stay IDLE, respond OKAY.
  - RUN, on each accepted beat (tvalid & tready):
    - The beat matches only if all DW/16 lanes equal expected.
    - On mismatch:
      - ERROR_COUNT++ (saturating);
      - if ERROR_COUNT was 0, latch frame and beat into FIRST_ERR_*.
    - expected <= expected+1; wraps 0xFFFF→0 and is never reset at frame boundaries.
    - If beat == beats_per_frame:
      - beat <= 1, FRAMES_RCVD++;
      - if frame == limit go to IDLE, else frame++.
    - Otherwise beat++.
  - A CONTROL write of 0 in RUN goes to IDLE the next cycle; counters are retained.
  - A nonzero CONTROL write in RUN is ignored and returns SLVERR.
- axis_in_tready = (state == RUN). The block never stalls a beat while in RUN.
- frame_size is sampled continuously. Software must not change it while busy; behaviour in that case is undefined but must not hang the AXI interface.

## Timing
- Reset values:
  - state IDLE, axis_in_tready 0;
  - all counters and FIRST_ERR_* 0, config_err 0;
  - AXI slave outputs idle (core defaults).
- Arm: the ASHI write is handled in cycle T; state = RUN and tready = 1 from T+1.
- Beat processing:
  - The counter update is registered: a beat accepted in cycle T is reflected in register reads from T+1.
  - The transition to IDLE after the last beat takes effect at T+1; tready is low at T+1.
- Abort together with a beat in the same cycle: the beat is fully processed (checked and counted), then state = IDLE.
- Last beat of the final frame together with an abort: same result, state IDLE.
- AXI read data reflects register state as of the cycle the ASHI read is handled; reads are one-cycle, as in the core.
- Reset asserted mid-frame: next cycle state IDLE, tready 0, all counters 0; the partial frame is discarded.

## Test plan
- frame_size=1024, DW=512, arm N=3, tvalid always high with a correct pattern -> 48 beats accepted, FRAMES_RCVD=3, ERROR_COUNT=0, CONTROL.bit0=0 at the cycle after beat 48, tready=0.
- Same setup, corrupt one lane of beat 5 of frame 2 -> ERROR_COUNT=1, FIRST_ERR_FRAME=2, FIRST_ERR_BEAT=5, FRAMES_RCVD=3.
- frame_size=64, N=70000, random tvalid gaps -> expected counter wraps 0xFFFF→0 with no errors, FRAMES_RCVD=70000.
- Arm N=10, write CONTROL=0 after 7 beats while beat 8 is accepted in the same cycle -> FRAMES_RCVD=0 (frame_size=1024), state IDLE next cycle, beat 8 checked; second nonzero write mid-run -> BRESP=SLVERR.
- frame_size=32 (< DW/8), arm N=1 -> CONTROL reads 0x2, tready stays 0; read index 7 -> RRESP=DECERR; write index 2 -> BRESP=SLVERR.
- resetn low for 1 cycle mid-frame -> tready=0 and all registers read 0; re-arm N=1 -> a clean frame passes with ERROR_COUNT=0.
